// File: rtl/multicycle_control_fsm.sv
// rtl/multicycle_control_fsm.sv - multicycle MIPS control sequencer with memory handshake and abort
module multicycle_control_fsm #(
  parameter int WAIT_LIMIT = 15,
  parameter int CNT_W      = 8
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [5:0] OP,
  input  logic [5:0] Funct,
  input  logic       Zero,
  input  logic       MemReady,
  output logic       PCWrite,
  output logic       IorD,
  output logic       MemRead,
  output logic       MemWrite,
  output logic       IRWrite,
  output logic       RegDst,
  output logic       MemToReg,
  output logic       RegWrite,
  output logic       ULASrcA,
  output logic [1:0] ULASrcB,
  output logic [2:0] ULAControl,
  output logic [1:0] PCSrc,
  output logic [3:0] State,
  output logic       InstrDone,
  output logic       Fault
);

  typedef enum logic [3:0] {
    S_FETCH    = 4'd0,
    S_DECODE   = 4'd1,
    S_MEMADR   = 4'd2,
    S_MEMREAD  = 4'd3,
    S_MEMWB    = 4'd4,
    S_MEMWRITE = 4'd5,
    S_EXECUTE  = 4'd6,
    S_ALUWB    = 4'd7,
    S_BRANCH   = 4'd8,
    S_IMMEXEC  = 4'd9,
    S_IMMWB    = 4'd10,
    S_JUMP     = 4'd11
  } state_t;

  state_t           state, state_next;
  logic [CNT_W-1:0] wait_cnt;
  logic             is_store;
  logic             waiting, timeout, wait_hit;

  // Timeout fires in the WAIT_LIMIT-th consecutive not-ready cycle.
  assign wait_hit = (wait_cnt == CNT_W'(WAIT_LIMIT - 1));
  assign State    = state;

  always_comb begin
    state_next = state;
    waiting    = 1'b0;
    timeout    = 1'b0;
    PCWrite    = 1'b0;
    IorD       = 1'b0;
    MemRead    = 1'b0;
    MemWrite   = 1'b0;
    IRWrite    = 1'b0;
    RegDst     = 1'b0;
    MemToReg   = 1'b0;
    RegWrite   = 1'b0;
    ULASrcA    = 1'b0;
    ULASrcB    = 2'b00;
    ULAControl = 3'b000;
    PCSrc      = 2'b00;
    InstrDone  = 1'b0;
    Fault      = 1'b0;
    case (state)
      S_FETCH: begin
        MemRead    = 1'b1;
        ULASrcB    = 2'b01;
        ULAControl = 3'b010;
        IRWrite    = MemReady;
        PCWrite    = MemReady;
        if (MemReady) state_next = S_DECODE;
        else begin
          waiting = 1'b1;
          timeout = wait_hit;
        end
      end
      S_DECODE: begin
        ULASrcB    = 2'b11;
        ULAControl = 3'b010;
        case (OP)
          6'b100011, 6'b101011:           state_next = S_MEMADR;
          6'b000000:                      state_next = S_EXECUTE;
          6'b000100:                      state_next = S_BRANCH;
          6'b001000, 6'b001100, 6'b001101: state_next = S_IMMEXEC;
          6'b000010:                      state_next = S_JUMP;
          default: begin
            Fault      = 1'b1;
            state_next = S_FETCH;
          end
        endcase
      end
      S_MEMADR: begin
        ULASrcA    = 1'b1;
        ULASrcB    = 2'b10;
        ULAControl = 3'b010;
        state_next = is_store ? S_MEMWRITE : S_MEMREAD;
      end
      S_MEMREAD: begin
        MemRead = 1'b1;
        IorD    = 1'b1;
        if (MemReady) state_next = S_MEMWB;
        else begin
          waiting = 1'b1;
          timeout = wait_hit;
        end
      end
      S_MEMWB: begin
        MemToReg   = 1'b1;
        RegWrite   = 1'b1;
        InstrDone  = 1'b1;
        state_next = S_FETCH;
      end
      S_MEMWRITE: begin
        MemWrite = 1'b1;
        IorD     = 1'b1;
        if (MemReady) begin
          InstrDone  = 1'b1;
          state_next = S_FETCH;
        end else begin
          waiting = 1'b1;
          timeout = wait_hit;
        end
      end
      S_EXECUTE: begin
        ULASrcA    = 1'b1;
        state_next = S_ALUWB;
        case (Funct)
          6'b100000: ULAControl = 3'b010;
          6'b100010: ULAControl = 3'b110;
          6'b100100: ULAControl = 3'b000;
          6'b100101: ULAControl = 3'b001;
          6'b101010: ULAControl = 3'b111;
          default: begin
            ULAControl = 3'b010;
            Fault      = 1'b1;
            state_next = S_FETCH;
          end
        endcase
      end
      S_ALUWB: begin
        RegDst     = 1'b1;
        RegWrite   = 1'b1;
        InstrDone  = 1'b1;
        state_next = S_FETCH;
      end
      S_BRANCH: begin
        ULASrcA    = 1'b1;
        ULAControl = 3'b110;
        PCSrc      = 2'b01;
        PCWrite    = Zero;
        InstrDone  = 1'b1;
        state_next = S_FETCH;
      end
      S_IMMEXEC: begin
        ULASrcA    = 1'b1;
        ULASrcB    = 2'b10;
        ULAControl = (OP == 6'b001100) ? 3'b000 :
                     (OP == 6'b001101) ? 3'b001 : 3'b010;
        state_next = S_IMMWB;
      end
      S_IMMWB: begin
        RegWrite   = 1'b1;
        InstrDone  = 1'b1;
        state_next = S_FETCH;
      end
      S_JUMP: begin
        PCSrc      = 2'b10;
        PCWrite    = 1'b1;
        InstrDone  = 1'b1;
        state_next = S_FETCH;
      end
      default: begin
        Fault      = 1'b1;
        state_next = S_FETCH;
      end
    endcase
    if (timeout) begin
      Fault      = 1'b1;
      MemRead    = 1'b0;
      MemWrite   = 1'b0;
      state_next = S_FETCH;
    end
    // Reset must silence every request without waiting for a clock edge.
    if (!rst_n) begin
      PCWrite    = 1'b0;
      IorD       = 1'b0;
      MemRead    = 1'b0;
      MemWrite   = 1'b0;
      IRWrite    = 1'b0;
      RegDst     = 1'b0;
      MemToReg   = 1'b0;
      RegWrite   = 1'b0;
      ULASrcA    = 1'b0;
      ULASrcB    = 2'b00;
      ULAControl = 3'b000;
      PCSrc      = 2'b00;
      InstrDone  = 1'b0;
      Fault      = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= S_FETCH;
      wait_cnt <= '0;
      is_store <= 1'b0;
    end else begin
      state <= state_next;
      if (state_next != state || timeout) wait_cnt <= '0;
      else if (waiting)                   wait_cnt <= wait_cnt + 1'b1;
      if (state == S_DECODE) is_store <= (OP == 6'b101011);
    end
  end

endmodule

// File: tb/tb_multicycle_control_fsm.sv
// tb/tb_multicycle_control_fsm.sv - directed self-checking bench for multicycle_control_fsm
module tb_multicycle_control_fsm;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [5:0] OP;
  logic [5:0] Funct;
  logic       Zero;
  logic       MemReady;
  logic       PCWrite, IorD, MemRead, MemWrite, IRWrite, RegDst, MemToReg, RegWrite, ULASrcA;
  logic [1:0] ULASrcB;
  logic [2:0] ULAControl;
  logic [1:0] PCSrc;
  logic [3:0] State;
  logic       InstrDone, Fault;

  int checks = 0;
  int errors = 0;

  multicycle_control_fsm #(.WAIT_LIMIT(15), .CNT_W(8)) dut (
    .clk(clk), .rst_n(rst_n), .OP(OP), .Funct(Funct), .Zero(Zero), .MemReady(MemReady),
    .PCWrite(PCWrite), .IorD(IorD), .MemRead(MemRead), .MemWrite(MemWrite),
    .IRWrite(IRWrite), .RegDst(RegDst), .MemToReg(MemToReg), .RegWrite(RegWrite),
    .ULASrcA(ULASrcA), .ULASrcB(ULASrcB), .ULAControl(ULAControl), .PCSrc(PCSrc),
    .State(State), .InstrDone(InstrDone), .Fault(Fault)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  // Advance to the next cycle; samples land 1ns after the falling edge.
  task automatic cyc();
    @(negedge clk);
    #1;
  endtask

  initial begin
    rst_n = 1'b0; OP = 6'b0; Funct = 6'b0; Zero = 1'b0; MemReady = 1'b1;
    cyc(); cyc();
    chk("rst_state", 32'(State), 0);
    chk("rst_memread", 32'(MemRead), 0);
    chk("rst_irwrite", 32'(IRWrite), 0);
    chk("rst_ulasrcb", 32'(ULASrcB), 0);
    rst_n = 1'b1;
    #1;
    // lw
    OP = 6'b100011;
    chk("lw_f_state", 32'(State), 0);
    chk("lw_f_memread", 32'(MemRead), 1);
    chk("lw_f_irwrite", 32'(IRWrite), 1);
    chk("lw_f_pcwrite", 32'(PCWrite), 1);
    chk("lw_f_ulasrcb", 32'(ULASrcB), 1);
    cyc();
    chk("lw_d_state", 32'(State), 1);
    chk("lw_d_ulasrcb", 32'(ULASrcB), 3);
    chk("lw_d_regwrite", 32'(RegWrite), 0);
    cyc();
    chk("lw_ma_state", 32'(State), 2);
    chk("lw_ma_ulasrcb", 32'(ULASrcB), 2);
    chk("lw_ma_ulasrca", 32'(ULASrcA), 1);
    cyc();
    chk("lw_mr_state", 32'(State), 3);
    chk("lw_mr_iord", 32'(IorD), 1);
    chk("lw_mr_memtoreg", 32'(MemToReg), 0);
    chk("lw_mr_done", 32'(InstrDone), 0);
    cyc();
    chk("lw_wb_state", 32'(State), 4);
    chk("lw_wb_memtoreg", 32'(MemToReg), 1);
    chk("lw_wb_regwrite", 32'(RegWrite), 1);
    chk("lw_wb_done", 32'(InstrDone), 1);
    cyc();
    chk("lw_end_state", 32'(State), 0);
    chk("lw_end_done", 32'(InstrDone), 0);

    // R-type sub
    OP = 6'b000000; Funct = 6'b100010;
    cyc();
    chk("sub_d_state", 32'(State), 1);
    cyc();
    chk("sub_ex_state", 32'(State), 6);
    chk("sub_ex_ctl", 32'(ULAControl), 3'b110);
    chk("sub_ex_srcb", 32'(ULASrcB), 0);
    cyc();
    chk("sub_wb_state", 32'(State), 7);
    chk("sub_wb_regdst", 32'(RegDst), 1);
    chk("sub_wb_regwrite", 32'(RegWrite), 1);
    cyc();
    chk("sub_end_state", 32'(State), 0);

    // R-type with illegal funct
    Funct = 6'b111111;
    cyc(); cyc();
    chk("badf_ex_state", 32'(State), 6);
    chk("badf_ex_fault", 32'(Fault), 1);
    chk("badf_ex_regwrite", 32'(RegWrite), 0);
    cyc();
    chk("badf_end_state", 32'(State), 0);
    chk("badf_end_fault", 32'(Fault), 0);
    chk("badf_end_regwrite", 32'(RegWrite), 0);

    // beq taken and not taken
    OP = 6'b000100; Zero = 1'b1;
    cyc(); cyc();
    chk("beq1_state", 32'(State), 8);
    chk("beq1_pcwrite", 32'(PCWrite), 1);
    chk("beq1_pcsrc", 32'(PCSrc), 1);
    chk("beq1_ctl", 32'(ULAControl), 3'b110);
    chk("beq1_done", 32'(InstrDone), 1);
    cyc();
    chk("beq1_end_state", 32'(State), 0);
    Zero = 1'b0;
    cyc(); cyc();
    chk("beq0_state", 32'(State), 8);
    chk("beq0_pcwrite", 32'(PCWrite), 0);
    cyc();
    chk("beq0_end_state", 32'(State), 0);

    // ori then j
    OP = 6'b001101;
    cyc(); cyc();
    chk("ori_ex_state", 32'(State), 9);
    chk("ori_ex_ctl", 32'(ULAControl), 3'b001);
    cyc();
    chk("ori_wb_state", 32'(State), 10);
    chk("ori_wb_regdst", 32'(RegDst), 0);
    chk("ori_wb_regwrite", 32'(RegWrite), 1);
    cyc();
    OP = 6'b000010;
    cyc(); cyc();
    chk("j_state", 32'(State), 11);
    chk("j_pcsrc", 32'(PCSrc), 2);
    chk("j_pcwrite", 32'(PCWrite), 1);
    cyc();
    chk("j_end_state", 32'(State), 0);

    // lw with 3 wait cycles in MEMREAD
    OP = 6'b100011;
    cyc(); cyc(); cyc();
    MemReady = 1'b0;
    #1;
    for (int i = 0; i < 3; i++) begin
      chk("wait_mr_state", 32'(State), 3);
      chk("wait_mr_fault", 32'(Fault), 0);
      chk("wait_mr_memread", 32'(MemRead), 1);
      cyc();
    end
    MemReady = 1'b1;
    #1;
    chk("wait_mr_last_state", 32'(State), 3);
    cyc();
    chk("wait_mr_wb_state", 32'(State), 4);
    chk("wait_mr_wb_fault", 32'(Fault), 0);
    cyc();

    // FETCH timeout after 15 not-ready cycles
    MemReady = 1'b0;
    #1;
    for (int i = 1; i <= 15; i++) begin
      chk("to_state", 32'(State), 0);
      chk("to_irwrite", 32'(IRWrite), 0);
      chk("to_pcwrite", 32'(PCWrite), 0);
      chk("to_fault", 32'(Fault), (i == 15) ? 1 : 0);
      cyc();
    end
    chk("to_restart_state", 32'(State), 0);
    chk("to_restart_fault", 32'(Fault), 0);
    chk("to_restart_memread", 32'(MemRead), 1);
    MemReady = 1'b1;
    #1;
    chk("to_restart_irwrite", 32'(IRWrite), 1);
    OP = 6'b001000;
    cyc();
    chk("to_decode_state", 32'(State), 1);
    cyc(); cyc(); cyc();
    chk("addi_end_state", 32'(State), 0);

    // sw, reset asynchronously while waiting in MEMWRITE
    OP = 6'b101011;
    cyc(); cyc();
    MemReady = 1'b0;
    cyc();
    chk("sw_mw_state", 32'(State), 5);
    chk("sw_mw_memwrite", 32'(MemWrite), 1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst_memwrite", 32'(MemWrite), 0);
    chk("arst_state", 32'(State), 0);
    chk("arst_memread", 32'(MemRead), 0);
    cyc();
    rst_n = 1'b1; MemReady = 1'b1; OP = 6'b111111;
    #1;
    chk("arst_rel_state", 32'(State), 0);
    cyc();
    chk("ill_d_state", 32'(State), 1);
    chk("ill_d_fault", 32'(Fault), 1);
    cyc();
    chk("ill_end_state", 32'(State), 0);
    chk("ill_end_fault", 32'(Fault), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
